// File: rtl/switch_pkg.sv
// Shared constants for the slide-switch input path and the switch-decode logic.
package switch_pkg;

    localparam int unsigned NUM_SW           = 8;
    localparam int unsigned DEBOUNCE_DEFAULT = 50000;
    localparam int unsigned DEBOUNCE_CNT_W   = 16;

    localparam int unsigned SW1_IDX = 0;
    localparam int unsigned SW2_IDX = 1;
    localparam int unsigned SW3_IDX = 2;
    localparam int unsigned SW4_IDX = 3;
    localparam int unsigned SW5_IDX = 4;
    localparam int unsigned SW6_IDX = 5;
    localparam int unsigned SW7_IDX = 6;
    localparam int unsigned SW8_IDX = 7;

    typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, debounced output flop
// and a one-cycle flag marking the edge on which the output flipped.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W        = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic upd
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_COUNT - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            db  <= 1'b0;
            upd <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            upd <= 1'b0;
            // Any return to the current level restarts the filter from zero.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CntMax) begin
                db  <= s2;
                cnt <= '0;
                upd <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debouncer8.sv
// Eight independent switch debouncers with a registered change strobe and change mask.
module switch_debouncer8
    import switch_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W        = DEBOUNCE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic              sw_changed,
    output logic [NUM_SW-1:0] sw_changed_mask
);

    if (STABLE_COUNT < 1 || 64'(STABLE_COUNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_count
        $fatal(1, "switch_debouncer8: STABLE_COUNT out of range for CNT_W");
    end

    sw_vec_t upd;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        debounce_bit #(
            .STABLE_COUNT(STABLE_COUNT),
            .CNT_W       (CNT_W)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sw_raw[i]),
            .db   (sw_db[i]),
            .upd  (upd[i])
        );
    end

    // Mask is only ever non-zero in the same cycle as the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_changed      <= 1'b0;
            sw_changed_mask <= '0;
        end else begin
            sw_changed      <= |upd;
            sw_changed_mask <= upd;
        end
    end

endmodule

// File: tb/tb_switch_debouncer8.sv
// Bench for switch_debouncer8: directed scenarios plus random switch activity against a
// history-based model of the debounce rule.
module tb_switch_debouncer8;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_raw, sw_db, sw_changed_mask;
    logic       sw_changed;
    logic [7:0] sw_raw1, sw_db1, mask1;
    logic       changed1;

    always #5 clk = ~clk;

    switch_debouncer8 #(.STABLE_COUNT(SC), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_raw         (sw_raw),
        .sw_db          (sw_db),
        .sw_changed     (sw_changed),
        .sw_changed_mask(sw_changed_mask)
    );

    switch_debouncer8 #(.STABLE_COUNT(1), .CNT_W(4)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_raw         (sw_raw1),
        .sw_db          (sw_db1),
        .sw_changed     (changed1),
        .sw_changed_mask(mask1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: raw value seen at each edge since reset release; output bit i flips at edge e
    // when the synchronised samples of the last SC edges all differ from it and at least SC
    // edges have passed since its previous flip.
    logic [7:0] samp[$];
    logic [7:0] mdl_db, mdl_upd, mdl_mask;
    logic       mdl_chg;
    int         last_flip[8];

    function automatic logic [7:0] smp(input int n);
        if (n < 1) return 8'h00;
        return samp[n-1];
    endfunction

    task automatic model_reset();
        samp.delete();
        mdl_db = 8'h00; mdl_upd = 8'h00; mdl_mask = 8'h00; mdl_chg = 1'b0;
        for (int i = 0; i < 8; i++) last_flip[i] = 0;
    endtask

    task automatic model_edge();
        int e;
        logic [7:0] upd, v;
        logic ok;
        samp.push_back(sw_raw);
        e = samp.size();
        mdl_mask = mdl_upd;
        mdl_chg  = |mdl_upd;
        upd = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (e - last_flip[i] >= SC) begin
                ok = 1'b1;
                for (int k = 0; k < SC; k++) begin
                    v = smp(e - 2 - k);
                    if (v[i] == mdl_db[i]) ok = 1'b0;
                end
                upd[i] = ok;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (upd[i]) begin
                mdl_db[i] = ~mdl_db[i];
                last_flip[i] = e;
            end
        end
        mdl_upd = upd;
    endtask

    task automatic tick(input logic [7:0] raw);
        sw_raw = raw;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_db;
        rst_n = 1'b0; sw_raw = 8'hFF; sw_raw1 = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sw_db !== 8'h00 || sw_changed !== 1'b0 || sw_changed_mask !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: db=%h chg=%b mask=%h, want 00/0/00",
                     sw_db, sw_changed, sw_changed_mask);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick(8'hFF);
            exp_db = (t >= 6) ? 8'hFF : 8'h00;
            n_tests++;
            if (sw_db !== exp_db || sw_changed !== (t == 7) ||
                sw_changed_mask !== ((t == 7) ? 8'hFF : 8'h00)) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: db=%h chg=%b mask=%h, want %h/%b/%h",
                         t, sw_db, sw_changed, sw_changed_mask, exp_db, (t == 7),
                         (t == 7) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_clean_change();
        int pulses = 0;
        logic [7:0] exp_db;
        repeat (12) tick(8'h00);
        n_tests++;
        if (sw_db !== 8'h00) begin
            n_fail++;
            $display("FAIL clean_settle: db=%h want 00", sw_db);
        end
        for (int t = 1; t <= 9; t++) begin
            tick(8'h55);
            exp_db = (t >= 6) ? 8'h55 : 8'h00;
            n_tests++;
            if (sw_db !== exp_db) begin
                n_fail++;
                $display("FAIL clean_db edge %0d: got %h want %h", t, sw_db, exp_db);
            end
            if (sw_changed) begin
                pulses++;
                n_tests++;
                if (sw_changed_mask !== 8'h55) begin
                    n_fail++;
                    $display("FAIL clean_mask: got %h want 55", sw_changed_mask);
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL clean_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic [7:0] lvl;
        repeat (12) tick(8'h00);
        for (int p = 0; p < 12; p++) begin
            lvl = ((p / 3) % 2 == 0) ? 8'h01 : 8'h00;
            tick(lvl);
            if (sw_changed) pulses++;
            n_tests++;
            if (sw_db[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_hold step %0d: db0=%b want 0", p, sw_db[0]);
            end
        end
        for (int t = 1; t <= 10; t++) begin
            tick(8'h01);
            if (sw_changed) pulses++;
            n_tests++;
            if (sw_db[0] !== (t >= 6)) begin
                n_fail++;
                $display("FAIL bounce_rise edge %0d: db0=%b want %b", t, sw_db[0], (t >= 6));
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_staggered();
        logic [7:0] masks[12];
        logic       chgs[12];
        int first = -1, nz = 0;
        for (int t = 0; t < 12; t++) begin
            tick((t == 0) ? 8'h09 : 8'h49);
            masks[t] = sw_changed_mask;
            chgs[t]  = sw_changed;
            if (sw_changed_mask != 8'h00) begin
                nz++;
                if (first < 0) first = t;
            end
        end
        n_tests++;
        if (first < 0 || first > 10 || nz != 2) begin
            n_fail++;
            $display("FAIL stagger_count: first=%0d nonzero=%0d want two pulses", first, nz);
        end else begin
            n_tests++;
            if (masks[first] !== 8'h08 || masks[first+1] !== 8'h40 ||
                chgs[first] !== 1'b1 || chgs[first+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL stagger_masks: got %h,%h chg %b%b want 08,40 chg 11",
                         masks[first], masks[first+1], chgs[first], chgs[first+1]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] raw = sw_raw;
        int fails = 0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 8; i++) if ($urandom_range(5) == 0) raw[i] = ~raw[i];
            tick(raw);
            n_tests++;
            if (sw_db !== mdl_db || sw_changed !== mdl_chg || sw_changed_mask !== mdl_mask) begin
                n_fail++;
                fails++;
                if (fails <= 10)
                    $display("FAIL random cyc %0d: db=%h chg=%b mask=%h, want %h/%b/%h", t,
                             sw_db, sw_changed, sw_changed_mask, mdl_db, mdl_chg, mdl_mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_db;
        repeat (12) tick(8'hF0);
        n_tests++;
        if (sw_db !== 8'hF0) begin
            n_fail++;
            $display("FAIL midrst_settle: db=%h want F0", sw_db);
        end
        tick(8'h0F);
        tick(8'h0F);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sw_db !== 8'h00 || sw_changed !== 1'b0 || sw_changed_mask !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: db=%h chg=%b mask=%h, want 00/0/00",
                     sw_db, sw_changed, sw_changed_mask);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int t = 1; t <= 8; t++) begin
            tick(8'h0F);
            exp_db = (t >= 6) ? 8'h0F : 8'h00;
            n_tests++;
            if (sw_db !== exp_db || sw_changed_mask !== ((t == 7) ? 8'h0F : 8'h00)) begin
                n_fail++;
                $display("FAIL midrst_release edge %0d: db=%h mask=%h, want %h/%h", t, sw_db,
                         sw_changed_mask, exp_db, (t == 7) ? 8'h0F : 8'h00);
            end
        end
    endtask

    task automatic test_sc1();
        sw_raw1 = 8'h80;
        for (int t = 1; t <= 5; t++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (sw_db1 !== ((t >= 3) ? 8'h80 : 8'h00) || changed1 !== (t == 4) ||
                mask1 !== ((t == 4) ? 8'h80 : 8'h00)) begin
                n_fail++;
                $display("FAIL sc1 edge %0d: db=%h chg=%b mask=%h, want %h/%b/%h", t, sw_db1,
                         changed1, mask1, (t >= 3) ? 8'h80 : 8'h00, (t == 4),
                         (t == 4) ? 8'h80 : 8'h00);
            end
        end
    endtask

    initial begin
        sw_raw = 8'h00; sw_raw1 = 8'h00; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_change();
        test_bounce();
        test_staggered();
        test_random();
        test_reset_mid();
        test_sc1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
